// File: rtl/serial_word_tx.sv
// MSB-first parallel-to-serial transmitter with frame_start/done strobes.
// Optional running mod-3 remainder outputs (rem, div3) when SERIAL_TX_MOD3_EN is defined.
module serial_word_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             Bit,
    output logic             bit_valid,
    output logic             frame_start,
`ifdef SERIAL_TX_MOD3_EN
    output logic [1:0]       rem,
    output logic             div3,
`endif
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load) begin
                    state_d = S_SHIFT;
                    shift_d = data_in;
                    cnt_d   = CW'(WIDTH - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // exit is decided on the old count so the counter never wraps
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        bit_valid_d   = (state_d == S_SHIFT);
        bit_d         = bit_valid_d & shift_d[WIDTH-1];
        frame_start_d = (state_d == S_SHIFT) && (state_q != S_SHIFT);
        done_d        = (state_d == S_DONE);
        ready_d       = (state_d != S_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            bit_q         <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
            ready_q       <= ready_d;
        end
    end

    assign ready       = ready_q;
    assign Bit         = bit_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;

`ifdef SERIAL_TX_MOD3_EN
    logic [1:0] rem_q, rem_d;
    logic       div3_q, div3_d;

    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        case ({r, b})
            3'b000:  mod3_step = 2'd0;
            3'b001:  mod3_step = 2'd1;
            3'b010:  mod3_step = 2'd2;
            3'b011:  mod3_step = 2'd0;
            3'b100:  mod3_step = 2'd1;
            3'b101:  mod3_step = 2'd2;
            default: mod3_step = 2'd0;
        endcase
    endfunction

    always_comb begin
        rem_d = rem_q;
        if (state_q == S_SHIFT)
            rem_d = mod3_step(rem_q, shift_q[WIDTH-1]);
        else if (state_d == S_SHIFT)
            rem_d = 2'd0;
        div3_d = (state_d == S_DONE) && (rem_d == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= 2'd0;
            div3_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            div3_q <= div3_d;
        end
    end

    assign rem  = rem_q;
    assign div3 = div3_q;
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed self-checking bench for serial_word_tx (WIDTH=8).
// Checks rem/div3 as well when SERIAL_TX_MOD3_EN is defined.
module tb_serial_word_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    logic       ready, bit_o, bit_valid, frame_start, done;
`ifdef SERIAL_TX_MOD3_EN
    logic [1:0] rem;
    logic       div3;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .data_in     (data_in),
        .ready       (ready),
        .Bit         (bit_o),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
`ifdef SERIAL_TX_MOD3_EN
        .rem         (rem),
        .div3        (div3),
`endif
        .done        (done)
    );

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; data_in = 8'h00;
        repeat (2) @(negedge clk);
        if ({bit_o, bit_valid, frame_start, done, ready} !== 5'b00001)
            $display("FAIL reset_outputs: got %b want 00001", {bit_o, bit_valid, frame_start, done, ready});
        else pass_cnt++;
        total_cnt++;
`ifdef SERIAL_TX_MOD3_EN
        if ({rem, div3} !== 3'b000) $display("FAIL reset_mod3: got %b want 000", {rem, div3});
        else pass_cnt++;
        total_cnt++;
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One frame from IDLE; data_in is scrambled after accept to prove it is not resampled.
    task automatic test_single(input logic [7:0] w, input string name,
                               input logic [1:0] exp_rem, input logic exp_div3);
        if (ready !== 1'b1) $display("FAIL %s ready_idle: got %b want 1", name, ready);
        else pass_cnt++;
        total_cnt++;
        load = 1'b1; data_in = w;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load = 1'b0; data_in = ~w;
            if ({bit_o, bit_valid, frame_start, ready, done} !== {w[7-k], 1'b1, (k == 0), 1'b0, 1'b0})
                $display("FAIL %s bit%0d: got %b want %b", name, k,
                         {bit_o, bit_valid, frame_start, ready, done}, {w[7-k], 1'b1, (k == 0), 1'b0, 1'b0});
            else pass_cnt++;
            total_cnt++;
        end
        @(negedge clk);
        if ({bit_o, bit_valid, frame_start, ready, done} !== 5'b00011)
            $display("FAIL %s done_cycle: got %b want 00011", name, {bit_o, bit_valid, frame_start, ready, done});
        else pass_cnt++;
        total_cnt++;
`ifdef SERIAL_TX_MOD3_EN
        if ({rem, div3} !== {exp_rem, exp_div3})
            $display("FAIL %s mod3: got %b want %b", name, {rem, div3}, {exp_rem, exp_div3});
        else pass_cnt++;
        total_cnt++;
`endif
        @(negedge clk);
        if ({bit_valid, done, ready} !== 3'b001)
            $display("FAIL %s after_done: got %b want 001", name, {bit_valid, done, ready});
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        w = 8'hFF;
        load = 1'b1; data_in = w;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                load = 1'b0;
                if ({bit_o, bit_valid, frame_start, ready} !== {w[7-k], 1'b1, (k == 0), 1'b0})
                    $display("FAIL b2b_f%0d bit%0d: got %b want %b", f, k,
                             {bit_o, bit_valid, frame_start, ready}, {w[7-k], 1'b1, (k == 0), 1'b0});
                else pass_cnt++;
                total_cnt++;
            end
            @(negedge clk);
            if ({bit_valid, done, ready} !== 3'b011)
                $display("FAIL b2b_f%0d done: got %b want 011", f, {bit_valid, done, ready});
            else pass_cnt++;
            total_cnt++;
`ifdef SERIAL_TX_MOD3_EN
            if (div3 !== 1'b1) $display("FAIL b2b_f%0d div3: got %b want 1", f, div3);
            else pass_cnt++;
            total_cnt++;
`endif
            if (f == 0) begin
                w = 8'h00;
                load = 1'b1; data_in = w;
            end
        end
        @(negedge clk);
        if ({bit_valid, done} !== 2'b00) $display("FAIL b2b_idle: got %b want 00", {bit_valid, done});
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_load_ignored();
        logic [7:0] w;
        w = 8'h06;
        load = 1'b1; data_in = w;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load = (k == 2); data_in = (k == 2) ? 8'hAA : w;
            if ({bit_o, bit_valid} !== {w[7-k], 1'b1})
                $display("FAIL ignore bit%0d: got %b want %b", k, {bit_o, bit_valid}, {w[7-k], 1'b1});
            else pass_cnt++;
            total_cnt++;
        end
        load = 1'b0;
        @(negedge clk);
        if (done !== 1'b1) $display("FAIL ignore done: got %b want 1", done);
        else pass_cnt++;
        total_cnt++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({bit_o, bit_valid} !== 2'b00)
                $display("FAIL ignore no_aa%0d: got %b want 00", c, {bit_o, bit_valid});
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        w = 8'h06;
        load = 1'b1; data_in = w;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            load = 1'b0;
            if ({bit_o, bit_valid} !== {w[7-k], 1'b1})
                $display("FAIL abort bit%0d: got %b want %b", k, {bit_o, bit_valid}, {w[7-k], 1'b1});
            else pass_cnt++;
            total_cnt++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if ({bit_o, bit_valid, frame_start, done, ready} !== 5'b00001)
            $display("FAIL abort outputs: got %b want 00001", {bit_o, bit_valid, frame_start, done, ready});
        else pass_cnt++;
        total_cnt++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({bit_valid, done} !== 2'b00) $display("FAIL abort no_done%0d: got %b want 00", c, {bit_valid, done});
            else pass_cnt++;
            total_cnt++;
        end
        test_single(8'h03, "after_abort_03", 2'd0, 1'b1);
    endtask

    task automatic test_reset_with_load();
        reset = 1'b1; load = 1'b1; data_in = 8'hAA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if ({bit_o, bit_valid, frame_start, done, ready} !== 5'b00001)
                $display("FAIL rst_load%0d: got %b want 00001", c, {bit_o, bit_valid, frame_start, done, ready});
            else pass_cnt++;
            total_cnt++;
        end
        reset = 1'b0; load = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if ({bit_valid, frame_start, ready} !== 3'b001)
                $display("FAIL rst_load_rel%0d: got %b want 001", c, {bit_valid, frame_start, ready});
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; data_in = 8'h00;
        test_reset();
        test_single(8'h06, "frame_06", 2'd0, 1'b1);
        test_single(8'h07, "frame_07", 2'd1, 1'b0);
        test_back_to_back();
        test_load_ignored();
        test_reset_mid_frame();
        test_reset_with_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
